// File: rtl/pll_mode_ctrl.sv
// Run-time PLLVR divider-preset controller: reset, lock wait, lock qualification.
// Optional relock counter output enabled by PLL_MODE_CTRL_RELOCK_CNT_EN.
module pll_mode_ctrl #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W = 2,
  parameter logic [18*NUM_MODES-1:0] MODE_TABLE = {NUM_MODES{18'h0}},
  parameter int RST_CYCLES = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] mode_req,
  input  logic              mode_req_valid,
  output logic              mode_req_ready,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [5:0]        fbdsel,
  output logic [5:0]        idsel,
  output logic [5:0]        odsel,
  output logic [MODE_W-1:0] cur_mode,
  output logic              clk_ready,
`ifdef PLL_MODE_CTRL_RELOCK_CNT_EN
  output logic [7:0]        relock_cnt,
`endif
  output logic              error
);

  localparam int RCW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TCW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SCW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int YW = $clog2(MAX_RETRIES + 1);

  localparam logic [RCW-1:0] RST_LAST =
    RCW'(RST_CYCLES - 1);
  localparam logic [TCW-1:0] TO_LAST =
    TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [SCW-1:0] STAB_LAST =
    SCW'(STABLE_CYCLES - 1);
  localparam logic [YW-1:0] RETRY_LAST =
    YW'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    S_ASSERT_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic [17:0]       sel_q;
  logic              load_sel;
  logic [YW-1:0]     retry_q;
  logic [YW-1:0]     retry_d;
  logic [RCW-1:0]    rst_cnt_q;
  logic [RCW-1:0]    rst_cnt_d;
  logic [TCW-1:0]    to_cnt_q;
  logic [TCW-1:0]    to_cnt_d;
  logic [SCW-1:0]    stab_cnt_q;
  logic [SCW-1:0]    stab_cnt_d;
  logic              lock_m;
  logic              lock_s;
  logic [MODE_W-1:0] req_mode;
  logic              req_fire;
  logic              mode_chg;

  function automatic logic [17:0] table_entry(
    input logic [MODE_W-1:0] m
  );
    return MODE_TABLE[18*int'(m) +: 18];
  endfunction

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Out-of-range requests fall back to preset 0
  assign req_mode =
    (32'(mode_req) < 32'(NUM_MODES)) ? mode_req : '0;
  assign req_fire = mode_req_valid && mode_req_ready;
  assign mode_chg = req_fire && (req_mode != mode_q);

  // State, applied mode, selectors and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_ASSERT_RST;
      mode_q     <= '0;
      sel_q      <= table_entry('0);
      retry_q    <= '0;
      rst_cnt_q  <= '0;
      to_cnt_q   <= '0;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      retry_q    <= retry_d;
      rst_cnt_q  <= rst_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stab_cnt_q <= stab_cnt_d;
      if (load_sel) begin
        sel_q <= table_entry(mode_d);
      end
    end
  end

  // Next-state logic; selectors reload only on entry to ASSERT_RST
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    load_sel   = 1'b0;
    retry_d    = retry_q;
    rst_cnt_d  = '0;
    to_cnt_d   = '0;
    stab_cnt_d = '0;
    unique case (state_q)
      S_ASSERT_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = S_STABLE;
          stab_cnt_d = SCW'(1);
        end else if (to_cnt_q == TO_LAST) begin
          retry_d = retry_q + 1'b1;
          if (retry_q == RETRY_LAST) begin
            state_d = S_ERROR;
          end else begin
            state_d  = S_ASSERT_RST;
            load_sel = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (mode_chg) begin
          state_d  = S_ASSERT_RST;
          mode_d   = req_mode;
          load_sel = 1'b1;
        end else if (!lock_s) begin
          state_d  = S_ASSERT_RST;
          load_sel = 1'b1;
        end
      end
      S_ERROR: begin
        if (req_fire) begin
          state_d  = S_ASSERT_RST;
          mode_d   = req_mode;
          load_sel = 1'b1;
          retry_d  = '0;
        end
      end
      default: begin
        state_d  = S_ASSERT_RST;
        load_sel = 1'b1;
      end
    endcase
  end

  // Status outputs decoded straight from the state register
  always_comb begin
    pll_reset      = 1'b0;
    clk_ready      = 1'b0;
    mode_req_ready = 1'b0;
    error          = 1'b0;
    unique case (1'b1)
      (state_q == S_ASSERT_RST): begin
        pll_reset = 1'b1;
      end
      (state_q == S_RUN): begin
        clk_ready      = 1'b1;
        mode_req_ready = 1'b1;
      end
      (state_q == S_ERROR): begin
        pll_reset      = 1'b1;
        mode_req_ready = 1'b1;
        error          = 1'b1;
      end
      default: begin
        pll_reset = 1'b0;
      end
    endcase
  end

  assign {fbdsel, idsel, odsel} = sel_q;
  assign cur_mode = mode_q;

`ifdef PLL_MODE_CTRL_RELOCK_CNT_EN
  logic relock_inc;

  assign relock_inc =
    (state_q == S_RUN) && !mode_chg && !lock_s;

  // Saturating count of lock-loss relocks from RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      relock_cnt <= 8'd0;
    end else if (relock_inc && relock_cnt != 8'hFF) begin
      relock_cnt <= relock_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_mode_ctrl.sv
// Bench for pll_mode_ctrl: directed scenarios then random PLL/request traffic.
// Outputs are compared each cycle against a phase/age reference model.
module tb_pll_mode_ctrl;

  localparam int NM = 3;
  localparam int RST_N = 16;
  localparam int STB_N = 32;
  localparam int TO_N = 128;
  localparam int RETRY_N = 3;
  localparam logic [17:0] E0 = 18'h12345;
  localparam logic [17:0] E1 = 18'h0ABCD;
  localparam logic [17:0] E2 = 18'h3C0F1;
  localparam logic [18*NM-1:0] TBL = {E2, E1, E0};

  localparam int P_RST = 0;
  localparam int P_WAIT = 1;
  localparam int P_STB = 2;
  localparam int P_RUN = 3;
  localparam int P_ERR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode_req = 2'd0;
  logic       mode_req_valid = 1'b0;
  logic       mode_req_ready;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] fbdsel;
  logic [5:0] idsel;
  logic [5:0] odsel;
  logic [1:0] cur_mode;
  logic       clk_ready;
  logic       error;
`ifdef PLL_MODE_CTRL_RELOCK_CNT_EN
  logic [7:0] relock_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit auto_on = 0;
  int lk_wait = 0;

  pll_mode_ctrl #(
    .NUM_MODES(NM),
    .MODE_W(2),
    .MODE_TABLE(TBL),
    .RST_CYCLES(RST_N),
    .STABLE_CYCLES(STB_N),
    .TIMEOUT_CYCLES(TO_N),
    .MAX_RETRIES(RETRY_N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode_req(mode_req),
    .mode_req_valid(mode_req_valid),
    .mode_req_ready(mode_req_ready),
    .pll_lock(pll_lock),
    .pll_reset(pll_reset),
    .fbdsel(fbdsel),
    .idsel(idsel),
    .odsel(odsel),
    .cur_mode(cur_mode),
    .clk_ready(clk_ready),
`ifdef PLL_MODE_CTRL_RELOCK_CNT_EN
    .relock_cnt(relock_cnt),
`endif
    .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: a phase, cycles spent in it, and the spec rules
  int m_ph = P_RST;
  int m_age = 0;
  int m_tries = 0;
  int m_mode = 0;
  int m_relk = 0;
  bit q1 = 0;
  bit q2 = 0;

  always @(posedge clk) begin
    bit ls;
    bit fire;
    int rm;
    if (reset) begin
      m_ph = P_RST; m_age = 0; m_tries = 0;
      m_mode = 0; m_relk = 0; q1 = 0; q2 = 0;
    end else begin
      ls = q2; q2 = q1; q1 = pll_lock;
      fire = mode_req_valid && (m_ph == P_RUN || m_ph == P_ERR);
      rm = (int'(mode_req) < NM) ? int'(mode_req) : 0;
      case (m_ph)
        P_RST: begin
          m_age++;
          if (m_age == RST_N) begin m_ph = P_WAIT; m_age = 0; end
        end
        P_WAIT: begin
          if (ls) begin
            m_ph = P_STB; m_age = 1;
          end else begin
            m_age++;
            if (m_age == TO_N) begin
              m_tries++; m_age = 0;
              m_ph = (m_tries == RETRY_N) ? P_ERR : P_RST;
            end
          end
        end
        P_STB: begin
          if (!ls) begin
            m_ph = P_WAIT; m_age = 0;
          end else begin
            m_age++;
            if (m_age == STB_N) begin m_ph = P_RUN; m_tries = 0; end
          end
        end
        P_RUN: begin
          if (fire && rm != m_mode) begin
            m_mode = rm; m_ph = P_RST; m_age = 0;
          end else if (!ls) begin
            m_ph = P_RST; m_age = 0;
            if (m_relk < 255) m_relk++;
          end
        end
        default: begin
          if (fire) begin
            m_mode = rm; m_tries = 0; m_ph = P_RST; m_age = 0;
          end
        end
      endcase
    end
  end

  function automatic logic [17:0] exp_sel(input int m);
    case (m)
      0: return E0;
      1: return E1;
      default: return E2;
    endcase
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pll_reset", 32'(pll_reset),
          32'(m_ph == P_RST || m_ph == P_ERR));
    check("clk_ready", 32'(clk_ready), 32'(m_ph == P_RUN));
    check("error", 32'(error), 32'(m_ph == P_ERR));
    check("req_ready", 32'(mode_req_ready),
          32'(m_ph == P_RUN || m_ph == P_ERR));
    check("cur_mode", 32'(cur_mode), 32'(m_mode));
    check("selectors", 32'({fbdsel, idsel, odsel}),
          32'(exp_sel(m_mode)));
    check("ready_vs_reset", 32'(clk_ready & pll_reset), 32'd0);
`ifdef PLL_MODE_CTRL_RELOCK_CNT_EN
    check("relock_cnt", 32'(relock_cnt), 32'(m_relk));
`endif
  endtask

  // Crude PLL: loses lock in reset, relocks after a random delay
  task automatic drive_rand();
    int r;
    if (reset) reset = 1'b0;
    if (pll_reset) begin
      pll_lock = 1'b0;
      r = $urandom_range(0, 9);
      if (r < 7) lk_wait = $urandom_range(10, 80);
      else if (r < 9) lk_wait = $urandom_range(140, 200);
      else lk_wait = 100000;
    end else if (lk_wait > 0) begin
      lk_wait--;
      pll_lock = (lk_wait == 0);
    end else begin
      r = $urandom_range(0, 999);
      if (r < 5) begin
        pll_lock = 1'b0; lk_wait = $urandom_range(1, 3);
      end else if (r < 7) begin
        pll_lock = 1'b0; lk_wait = 300;
      end else begin
        pll_lock = 1'b1;
      end
    end
    mode_req_valid = ($urandom_range(0, 39) == 0);
    mode_req = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 2999) == 0) begin
      #3 reset = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    if (auto_on) drive_rand();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic bit cond(input int which);
    case (which)
      0: return clk_ready;
      1: return !pll_reset;
      2: return error;
      default: return pll_reset;
    endcase
  endfunction

  // Bounded wait; an expired bound shows up as a failed check
  task automatic wait_for(input string tag, input int which,
                          input int limit, output int n);
    n = 0;
    while (!cond(which) && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(cond(which)), 32'd1);
  endtask

  initial begin
    int n;
    ticks(3);
    reset = 1'b0;

    // Reset release, lock 100 cycles later
    wait_for("rst_done", 1, 100, n);
    check("rst_len", n, RST_N);
    ticks(100 - RST_N);
    pll_lock = 1'b1;
    wait_for("first_ready", 0, 500, n);
    check("lock_to_ready", n, 2 + STB_N);
    check("sel_mode0", 32'({fbdsel, idsel, odsel}), 32'(E0));

    // Mode change to 2
    mode_req = 2'd2; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    check("chg_ready_drop", 32'(clk_ready), 32'd0);
    check("chg_mode", 32'(cur_mode), 32'd2);
    check("chg_sel", 32'({fbdsel, idsel, odsel}), 32'(E2));
    wait_for("chg_ready", 0, 500, n);

    // Lock loss, then a glitch part way through qualification
    pll_lock = 1'b0;
    wait_for("relock_rst", 3, 20, n);
    wait_for("relock_wait", 1, 100, n);
    ticks(5);
    pll_lock = 1'b1;
    ticks(22);
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    wait_for("glitch_ready", 0, 500, n);
    check("glitch_to_ready", n, 2 + STB_N);
`ifdef PLL_MODE_CTRL_RELOCK_CNT_EN
    check("relock_one", 32'(relock_cnt), 32'd1);
`endif

    // Lock never returns: retries exhaust into ERROR
    pll_lock = 1'b0;
    wait_for("err_set", 2, 2000, n);
    check("err_pll_reset", 32'(pll_reset), 32'd1);
    mode_req = 2'd1; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    check("err_clear", 32'(error), 32'd0);
    check("err_mode", 32'(cur_mode), 32'd1);
    pll_lock = 1'b1;
    wait_for("err_ready", 0, 500, n);

    // Out-of-range request clamps to 0; WAIT ignores requests
    pll_lock = 1'b0;
    mode_req = 2'd3; mode_req_valid = 1'b1;
    tick();
    mode_req_valid = 1'b0;
    check("clamp_mode", 32'(cur_mode), 32'd0);
    wait_for("clamp_wait", 1, 100, n);
    mode_req = 2'd2; mode_req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("wait_not_ready", 32'(mode_req_ready), 32'd0);
    end
    mode_req_valid = 1'b0;
    pll_lock = 1'b1;
    wait_for("clamp_ready", 0, 500, n);
    check("ignored_req", 32'(cur_mode), 32'd0);

    // Random traffic against the model
    auto_on = 1;
    ticks(16000);
    auto_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
